// File: rtl/cart_arb.sv
// cart_arb: arbitrates CPU read/write and DMA read requests onto a single cart_iface port,
// with a bounded busy wait that aborts the transaction (reads return 8'hFF) on timeout.
module cart_arb #(
  parameter bit DMA_PRIO = 1'b1,
  parameter int WAIT_MAX = 255
) (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  input  logic [15:0] dma_addr,
  input  logic        dma_rd,
  output logic        dma_ack,
  output logic [7:0]  dma_dout,
  output logic [15:0] cif_addr,
  output logic [7:0]  cif_din,
  output logic        cif_rd,
  output logic        cif_wr,
  input  logic        cif_busy,
  input  logic [7:0]  cif_dout,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, STB, WAIT, DONE} state_t;
  localparam logic [7:0] LP_MAX = 8'(WAIT_MAX);
  state_t     r_state;
  logic       r_gnt_dma;
  logic       r_wr;
  logic       r_rr_cpu;
  logic [7:0] r_cnt;
  logic       w_cpu_req;
  logic       w_pick_dma;
  logic       w_wr;
  logic       w_end;
  logic [7:0] w_rdata;
  assign w_cpu_req  = cpu_rd | cpu_wr;
  // r_rr_cpu set means the CPU wins the next tie in round-robin mode
  assign w_pick_dma = dma_rd & (~w_cpu_req | DMA_PRIO | ~r_rr_cpu);
  assign w_wr       = ~w_pick_dma & cpu_wr;
  // the first WAIT cycle (counter 0) never ends the wait
  assign w_end      = (r_cnt != 8'd0) & (~cif_busy | (r_cnt == LP_MAX));
  assign w_rdata    = cif_busy ? 8'hFF : cif_dout;
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt_dma <= 1'b0;
      r_wr      <= 1'b0;
      r_rr_cpu  <= 1'b1;
      r_cnt     <= 8'd0;
      cpu_ack   <= 1'b0;
      cpu_dout  <= 8'd0;
      dma_ack   <= 1'b0;
      dma_dout  <= 8'd0;
      cif_addr  <= 16'd0;
      cif_din   <= 8'd0;
      cif_rd    <= 1'b0;
      cif_wr    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cif_rd  <= 1'b0;
      cif_wr  <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      timeout <= 1'b0;
      case (r_state)
        IDLE: if (w_cpu_req | dma_rd) begin
          r_gnt_dma <= w_pick_dma;
          r_wr      <= w_wr;
          cif_addr  <= w_pick_dma ? dma_addr : cpu_addr;
          if (w_wr) cif_din <= cpu_din;
          cif_rd    <= ~w_wr;
          cif_wr    <= w_wr;
          r_state   <= STB;
        end
        STB: begin
          r_cnt   <= 8'd0;
          r_state <= WAIT;
        end
        WAIT: if (w_end) begin
          r_state  <= DONE;
          timeout  <= cif_busy;
          cpu_ack  <= ~r_gnt_dma;
          dma_ack  <= r_gnt_dma;
          r_rr_cpu <= r_gnt_dma;
          if (!r_wr && r_gnt_dma) dma_dout <= w_rdata;
          if (!r_wr && !r_gnt_dma) cpu_dout <= w_rdata;
        end else r_cnt <= r_cnt + 8'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cart_arb.sv
// tb_cart_arb: two arbiters (DMA priority / WAIT_MAX=4 and round-robin / WAIT_MAX=10) driven by
// randomized requests, with a cart_iface model and queue-based scoreboard per instance.
module tb_cart_arb;
  typedef struct { bit wr; logic [15:0] addr; logic [7:0] din; int b; logic [7:0] dat; } stb_t;
  typedef struct { bit dma; bit rd; logic [7:0] dat; bit to; int cyc; } ack_t;

  logic        clk_8m = 1'b0;
  logic [1:0]  rst = 2'b11;
  logic [15:0] cpu_addr [2];
  logic [7:0]  cpu_din [2];
  logic [1:0]  cpu_rd = 2'b00, cpu_wr = 2'b00, dma_rd = 2'b00;
  logic [1:0]  cpu_ack, dma_ack, cif_rd, cif_wr, timeout;
  logic [1:0]  cif_busy = 2'b00;
  logic [7:0]  cpu_dout [2];
  logic [7:0]  dma_dout [2];
  logic [15:0] dma_addr [2];
  logic [15:0] cif_addr [2];
  logic [7:0]  cif_din [2];
  logic [7:0]  cif_dout [2];

  int   checks = 0, errors = 0, cyc = 0;
  int   bc [2];
  bit   pri_cpu [2];
  logic [7:0] md_cpu [2];
  logic [7:0] md_dma [2];
  stb_t stq [2][$];
  ack_t akq [2][$];

  cart_arb #(.DMA_PRIO(1'b1), .WAIT_MAX(4)) u0 (
    .clk_8m(clk_8m), .rst(rst[0]), .cpu_addr(cpu_addr[0]), .cpu_din(cpu_din[0]),
    .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]), .cpu_ack(cpu_ack[0]), .cpu_dout(cpu_dout[0]),
    .dma_addr(dma_addr[0]), .dma_rd(dma_rd[0]), .dma_ack(dma_ack[0]), .dma_dout(dma_dout[0]),
    .cif_addr(cif_addr[0]), .cif_din(cif_din[0]), .cif_rd(cif_rd[0]), .cif_wr(cif_wr[0]),
    .cif_busy(cif_busy[0]), .cif_dout(cif_dout[0]), .timeout(timeout[0]));
  cart_arb #(.DMA_PRIO(1'b0), .WAIT_MAX(10)) u1 (
    .clk_8m(clk_8m), .rst(rst[1]), .cpu_addr(cpu_addr[1]), .cpu_din(cpu_din[1]),
    .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]), .cpu_ack(cpu_ack[1]), .cpu_dout(cpu_dout[1]),
    .dma_addr(dma_addr[1]), .dma_rd(dma_rd[1]), .dma_ack(dma_ack[1]), .dma_dout(dma_dout[1]),
    .cif_addr(cif_addr[1]), .cif_din(cif_din[1]), .cif_rd(cif_rd[1]), .cif_wr(cif_wr[1]),
    .cif_busy(cif_busy[1]), .cif_dout(cif_dout[1]), .timeout(timeout[1]));

  always #5 clk_8m = ~clk_8m;
  always @(posedge clk_8m) cyc <= cyc + 1;

  function automatic int wm(input int k);
    return (k == 0) ? 4 : 10;
  endfunction
  function automatic bit dp(input int k);
    return k == 0;
  endfunction
  // busy is sampled high in WAIT cycle w iff w < b; the wait ends at the first w >= 1 with busy low, or at WAIT_MAX
  function automatic int wdone(input int b, input int m);
    return (b > m) ? m : ((b < 1) ? 1 : b);
  endfunction
  function automatic logic [63:0] outs(input int k);
    return {cif_rd[k], cif_wr[k], cpu_ack[k], dma_ack[k], timeout[k], cif_addr[k], cif_din[k], cpu_dout[k], dma_dout[k]};
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (u%0d): got %0h expected %0h at cycle %0d", nm, k, act, exp, cyc);
    end
  endtask

  // scoreboard checks plus the cart_iface model, one per instance
  always @(negedge clk_8m) begin
    ack_t e;
    stb_t s;
    for (int k = 0; k < 2; k++) if (!rst[k]) begin
      if (cpu_ack[k] | dma_ack[k]) begin
        if (akq[k].size() == 0) chk("unexpected_ack", k, {cpu_ack[k], dma_ack[k]}, 0);
        else begin
          e = akq[k].pop_front();
          chk("ack_who", k, {cpu_ack[k], dma_ack[k]}, e.dma ? 2'b01 : 2'b10);
          chk("ack_cycle", k, cyc, e.cyc);
          chk("timeout", k, timeout[k], e.to);
          if (e.rd && e.dma) md_dma[k] = e.dat;
          if (e.rd && !e.dma) md_cpu[k] = e.dat;
          chk("cpu_dout", k, cpu_dout[k], md_cpu[k]);
          chk("dma_dout", k, dma_dout[k], md_dma[k]);
        end
      end else if (timeout[k]) chk("timeout_without_ack", k, timeout[k], 0);
      if (cif_rd[k] | cif_wr[k]) begin
        chk("strobe_exclusive", k, cif_rd[k] & cif_wr[k], 0);
        if (stq[k].size() == 0) chk("unexpected_strobe", k, {cif_rd[k], cif_wr[k]}, 0);
        else begin
          s = stq[k].pop_front();
          chk("strobe_kind", k, {cif_rd[k], cif_wr[k]}, s.wr ? 2'b01 : 2'b10);
          chk("cif_addr", k, cif_addr[k], s.addr);
          if (s.wr) chk("cif_din", k, cif_din[k], s.din);
          bc[k] = s.b;
          cif_dout[k] = s.dat;
        end
      end else if (bc[k] > 0) begin
        cif_busy[k] = 1'b1;
        bc[k]--;
      end else cif_busy[k] = 1'b0;
    end
  end

  // called on a negedge with the DUT idle; returns on the negedge of the following idle cycle
  task automatic txn(input int k, input bit ce, input bit cw, input bit cboth, input logic [15:0] ca,
                     input logic [7:0] cd, input int cb, input logic [7:0] cdat,
                     input bit de, input logic [15:0] da, input int db, input logic [7:0] ddat);
    bit fd;
    int t;
    fd = de && (!ce || dp(k) || !pri_cpu[k]);
    t = cyc + 1;
    for (int i = 0; i < int'(ce) + int'(de); i++) begin
      bit d;
      bit w;
      int b;
      logic [7:0] x;
      d = (i == 0) ? fd : !fd;
      w = !d && cw;
      b = d ? db : cb;
      x = d ? ddat : cdat;
      t += 2 + wdone(b, wm(k));
      stq[k].push_back(stb_t'{w, d ? da : ca, cd, b, x});
      akq[k].push_back(ack_t'{d, !w, (b > wm(k)) ? 8'hFF : x, b > wm(k), t});
      pri_cpu[k] = d;
      t += 2;
    end
    cpu_addr[k] = ca;
    cpu_din[k]  = cd;
    dma_addr[k] = da;
    cpu_rd[k]   = ce && (cboth || !cw);
    cpu_wr[k]   = ce && cw;
    dma_rd[k]   = de;
    for (int n = 0; n < 200 && (cpu_rd[k] | cpu_wr[k] | dma_rd[k]); n++) begin
      @(negedge clk_8m);
      if (cpu_ack[k]) begin
        cpu_rd[k] = 1'b0;
        cpu_wr[k] = 1'b0;
      end
      if (dma_ack[k]) dma_rd[k] = 1'b0;
    end
    chk("handshake_bound", k, {cpu_rd[k], cpu_wr[k], dma_rd[k]}, 0);
    cpu_rd[k] = 1'b0;
    cpu_wr[k] = 1'b0;
    dma_rd[k] = 1'b0;
    @(negedge clk_8m);
  endtask

  task automatic rst_test(input int k);
    stq[k].push_back(stb_t'{1'b0, 16'h5A5A, 8'h00, 30, 8'h11});
    cpu_addr[k] = 16'h5A5A;
    cpu_rd[k] = 1'b1;
    repeat (3) @(negedge clk_8m);
    rst[k] = 1'b1;
    #1;
    chk("reset_mid_wait_outputs", k, outs(k), 0);
    cpu_rd[k] = 1'b0;
    md_cpu[k] = 8'h00;
    md_dma[k] = 8'h00;
    pri_cpu[k] = 1'b1;
    bc[k] = 0;
    cif_busy[k] = 1'b0;
    @(negedge clk_8m);
    rst[k] = 1'b0;
    @(negedge clk_8m);
  endtask

  task automatic run(input int k);
    txn(k, 1, 0, 0, 16'hAA55, 8'h00, 9, 8'hAA, 0, 16'h0000, 0, 8'h00);
    txn(k, 1, 1, 0, 16'hA5A5, 8'hA5, 3, 8'h00, 0, 16'h0000, 0, 8'h00);
    txn(k, 1, 1, 1, 16'h0101, 8'h3C, 1, 8'h00, 0, 16'h0000, 0, 8'h00);
    txn(k, 1, 0, 0, 16'h1234, 8'h00, 2, 8'h12, 1, 16'h8000, 1, 8'h80);
    txn(k, 1, 0, 0, 16'h0F0F, 8'h00, 0, 8'h77, 0, 16'h0000, 0, 8'h00);
    txn(k, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 16'hC000, 6, 8'h44);
    txn(k, 1, 0, 0, 16'hBEEF, 8'h00, wm(k), 8'h99, 0, 16'h0000, 0, 8'h00);
    txn(k, 1, 0, 0, 16'hBEF0, 8'h00, wm(k) + 1, 8'h98, 0, 16'h0000, 0, 8'h00);
    txn(k, 1, 1, 0, 16'h2222, 8'h5D, 2, 8'h00, 1, 16'h3333, 0, 8'h66);
    repeat (40) begin
      int v;
      v = $urandom_range(1, 3);
      txn(k, v[0], $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16'($urandom), 8'($urandom),
          $urandom_range(0, wm(k) + 3), 8'($urandom),
          v[1], 16'($urandom), $urandom_range(0, wm(k) + 3), 8'($urandom));
    end
    txn(k, 1, 0, 0, 16'h4444, 8'h00, 2, 8'h4A, 0, 16'h0000, 0, 8'h00);
    rst_test(k);
    txn(k, 1, 0, 0, 16'h1234, 8'h00, 2, 8'hC1, 1, 16'h8000, 3, 8'hD1);
    txn(k, 1, 0, 0, 16'h6666, 8'h00, 0, 8'hE6, 0, 16'h0000, 0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      cpu_addr[k] = 16'h0; cpu_din[k] = 8'h0; dma_addr[k] = 16'h0; cif_dout[k] = 8'h0;
      bc[k] = 0; pri_cpu[k] = 1'b1; md_cpu[k] = 8'h0; md_dma[k] = 8'h0;
    end
    repeat (2) @(negedge clk_8m);
    for (int k = 0; k < 2; k++) chk("reset_outputs", k, outs(k), 0);
    rst = 2'b00;
    @(negedge clk_8m);
    fork
      run(0);
      run(1);
    join
    for (int k = 0; k < 2; k++) begin
      chk("ack_queue_drained", k, akq[k].size(), 0);
      chk("strobe_queue_drained", k, stq[k].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cart_arb.md
CART_ARB -- requirements
Module: cart_arb

Interface
REQ-001 Parameter DMA_PRIO, default 1: 1 = DMA wins simultaneous requests; 0 = round-robin, starting with CPU after reset.
REQ-002 Parameter WAIT_MAX, default 255: maximum cycles spent in WAIT before timeout, range 1..255.
REQ-003 clk_8m  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cpu_addr  in  16  CPU cart address, held stable while a request is pending.
REQ-006 cpu_din  in  8  CPU write data, held stable while cpu_wr is high.
REQ-007 cpu_rd / cpu_wr  in  1 each  level requests, held until cpu_ack.
REQ-008 cpu_ack  out  1  one-cycle completion pulse to the CPU.
REQ-009 cpu_dout  out  8  read data, valid from cpu_ack until the next CPU read completes.
REQ-010 dma_addr  in  16  DMA source address, held stable while dma_rd is high.
REQ-011 dma_rd  in  1  DMA read request (read-only), level, held until dma_ack.
REQ-012 dma_ack / dma_dout  out  1 / 8  same semantics as the CPU pair.
REQ-013 cif_addr / cif_din  out  16 / 8  address and write data to cart_iface.
REQ-014 cif_rd / cif_wr  out  1 each  one-cycle command strobes to cart_iface.
REQ-015 cif_busy  in  1  cart_iface busy; may first rise one cycle after a strobe.
REQ-016 cif_dout  in  8  cart_iface read data, valid when busy is low after a read.
REQ-017 timeout  out  1  one-cycle pulse when a transaction is aborted.

Function
REQ-018 The FSM SHALL have the states IDLE, STB, WAIT and DONE; all outputs SHALL be registered.
REQ-019 IDLE: if any request is high, latch the grant, address and data, and go to STB; otherwise stay.
REQ-020 If cpu_rd and cpu_wr are both high, the block SHALL perform a write only.
REQ-021 Round-robin: on a tie, the requester not served last wins; the last-served record updates on entry to DONE.
REQ-022 STB lasts exactly one cycle with cif_rd or cif_wr high and cif_addr/cif_din driven; then WAIT.
REQ-023 WAIT: cif_busy is ignored in the first WAIT cycle; afterwards, cif_busy low at an edge -> DONE.
REQ-024 Entry to DONE from a read SHALL capture cif_dout into the granted requester's dout register.
REQ-025 DONE lasts one cycle with the granted requester's ack high; then IDLE.
REQ-026 A CPU write SHALL leave cpu_dout unchanged.
REQ-027 The WAIT cycle counter SHALL be 8 bits and reset to 0 on entry to WAIT.
REQ-028 When the counter reaches WAIT_MAX with cif_busy still high, the block SHALL go to DONE.
REQ-029 On that timeout: assert timeout with ack; for a read, load dout with 8'hFF.
REQ-030 cif_addr and cif_din SHALL hold their last values outside STB; cif_rd and cif_wr SHALL be 0 outside STB.
REQ-031 Requests changing during STB, WAIT or DONE SHALL be ignored until IDLE.
REQ-032 Latency from request (sampled in IDLE) to ack SHALL be 4 cycles minimum, with at least 1 IDLE cycle between transactions.

Reset
REQ-033 rst high SHALL immediately force IDLE and the round-robin record to CPU.
REQ-034 rst high SHALL immediately force all outputs to 0, including cif_rd/cif_wr mid-transaction.
REQ-035 rst high SHALL clear the wait counter.
REQ-036 After rst, an in-flight transaction SHALL be dropped with no ack.

Verification
REQ-037 CPU read 16'hAA55, cart_iface returns 8'hAA after 9 busy cycles -> one cif_rd pulse with cif_addr=AA55, then cpu_ack with cpu_dout=AA; dma_ack stays 0.
REQ-038 CPU write 8'hA5 to 16'hA5A5 -> one cif_wr pulse with cif_din=A5; cpu_ack; cpu_dout unchanged; cif_rd never high.
REQ-039 cpu_rd(1234) and dma_rd(8000) in the same IDLE cycle, DMA_PRIO=1 -> DMA served first, then CPU; with DMA_PRIO=0 after reset -> CPU first; exactly one strobe per transaction.
REQ-040 cif_busy held high, WAIT_MAX=4, CPU read -> cpu_ack with timeout pulse in the same cycle, cpu_dout=FF, then return to IDLE.
REQ-041 rst asserted during WAIT -> all outputs 0 in the same cycle; no ack; the next request after release completes normally.
REQ-042 cif_busy never rises after the strobe -> DONE after the second WAIT cycle, giving a 4-cycle request-to-ack latency.
